// File: rtl/instr_encoder.sv
// instr_encoder
//   Packs symbolic LEGv8 instruction requests into 32-bit machine words and
//   writes them to consecutive instruction-memory addresses through a
//   one-entry output stage with backpressure.
//
// Ports
//   clk        : system clock, rising edge
//   reset      : asynchronous active-low reset
//   in_valid   : request present
//   in_ready   : request can be accepted this cycle (combinational)
//   op         : mnemonic (0 B .. 11 MOVZ, 12-15 illegal)
//   rd/rn/rm   : register fields
//   hw         : MOVK/MOVZ shift select
//   imm        : raw two's-complement immediate, interpreted per op
//   addr_load  : load write pointer from load_addr (low two bits forced to 0)
//   wr_en      : output word valid
//   wr_ready   : memory accepts the word
//   wr_addr    : byte address of wr_data
//   wr_data    : encoded instruction
//   err        : one-cycle pulse for a rejected request
//   err_sticky : set by any err pulse, cleared by reset only
//   count      : words written to memory, wrapping
module instr_encoder #(
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            op,
  input  logic [4:0]            rd,
  input  logic [4:0]            rn,
  input  logic [4:0]            rm,
  input  logic [1:0]            hw,
  input  logic [25:0]           imm,
  input  logic                  addr_load,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  output logic                  wr_en,
  input  logic                  wr_ready,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [31:0]           wr_data,
  output logic                  err,
  output logic                  err_sticky,
  output logic [ADDR_WIDTH-3:0] count
);

  localparam int unsigned AW    = ADDR_WIDTH;
  localparam int unsigned CNT_W = ADDR_WIDTH - 2;
  localparam int unsigned WORD_W = 32;

  localparam logic [3:0] OP_B     = 4'd0;
  localparam logic [3:0] OP_CBZ   = 4'd1;
  localparam logic [3:0] OP_B_LT  = 4'd2;
  localparam logic [3:0] OP_ADDS  = 4'd3;
  localparam logic [3:0] OP_SUBS  = 4'd4;
  localparam logic [3:0] OP_ADDI  = 4'd5;
  localparam logic [3:0] OP_LDUR  = 4'd6;
  localparam logic [3:0] OP_LDURB = 4'd7;
  localparam logic [3:0] OP_STUR  = 4'd8;
  localparam logic [3:0] OP_STURB = 4'd9;
  localparam logic [3:0] OP_MOVK  = 4'd10;
  localparam logic [3:0] OP_MOVZ  = 4'd11;

  // State registers
  logic              r_wr_en;
  logic [AW-1:0]     r_wr_addr;
  logic [WORD_W-1:0] r_wr_data;
  logic              r_err;
  logic              r_err_sticky;
  logic [CNT_W-1:0]  r_count;
  logic [AW-1:0]     r_ptr;

  // Next-state values
  logic              w_wr_en_nxt;
  logic [AW-1:0]     w_wr_addr_nxt;
  logic [WORD_W-1:0] w_wr_data_nxt;
  logic              w_err_nxt;
  logic              w_err_sticky_nxt;
  logic [CNT_W-1:0]  w_count_nxt;
  logic [AW-1:0]     w_ptr_nxt;

  logic              w_accept;
  logic              w_drain;
  logic              w_legal;
  logic [WORD_W-1:0] w_word;
  logic              w_br_ok;
  logic              w_dt_ok;
  logic              w_addi_ok;
  logic              w_mov_ok;
  logic [AW-1:0]     w_load_aligned;
  logic [AW-1:0]     w_base;

  // Immediate range checks: sign-extension of 19- and 9-bit fields, unsigned 12/16-bit
  assign w_br_ok   = (imm[25:18] == {8{imm[18]}});
  assign w_dt_ok   = (imm[25:8]  == {18{imm[8]}});
  assign w_addi_ok = (imm[25:12] == 14'd0);
  assign w_mov_ok  = (imm[25:16] == 10'd0);

  // Instruction packing and legality
  always_comb begin
    w_word  = '0;
    w_legal = 1'b0;
    case (op)
      OP_B: begin
        w_word  = {6'b000101, imm};
        w_legal = 1'b1;
      end
      OP_CBZ: begin
        w_word  = {8'b10110100, imm[18:0], rd};
        w_legal = w_br_ok;
      end
      OP_B_LT: begin
        w_word  = {8'b01010100, imm[18:0], 1'b0, 4'b1011};
        w_legal = w_br_ok;
      end
      OP_ADDS: begin
        w_word  = {11'b10101011000, rm, 6'b000000, rn, rd};
        w_legal = 1'b1;
      end
      OP_SUBS: begin
        w_word  = {11'b11101011000, rm, 6'b000000, rn, rd};
        w_legal = 1'b1;
      end
      OP_ADDI: begin
        w_word  = {10'b1001000100, imm[11:0], rn, rd};
        w_legal = w_addi_ok;
      end
      OP_LDUR: begin
        w_word  = {11'b11111000010, imm[8:0], 2'b00, rn, rd};
        w_legal = w_dt_ok;
      end
      OP_LDURB: begin
        w_word  = {11'b00111000010, imm[8:0], 2'b00, rn, rd};
        w_legal = w_dt_ok;
      end
      OP_STUR: begin
        w_word  = {11'b11111000000, imm[8:0], 2'b00, rn, rd};
        w_legal = w_dt_ok;
      end
      OP_STURB: begin
        w_word  = {11'b00111000000, imm[8:0], 2'b00, rn, rd};
        w_legal = w_dt_ok;
      end
      OP_MOVK: begin
        w_word  = {9'b111100101, hw, imm[15:0], rd};
        w_legal = w_mov_ok;
      end
      OP_MOVZ: begin
        w_word  = {9'b110100101, hw, imm[15:0], rd};
        w_legal = w_mov_ok;
      end
      default: begin
        w_word  = '0;
        w_legal = 1'b0;
      end
    endcase
  end

  // A new word may enter in the same cycle the held word drains
  assign in_ready = !r_wr_en || wr_ready;
  assign w_accept = in_valid && in_ready;
  assign w_drain  = r_wr_en && wr_ready;

  assign w_load_aligned = load_addr & ~AW'(3);
  assign w_base         = addr_load ? w_load_aligned : r_ptr;

  // Next-state logic for output stage, pointer, error flags and counter
  always_comb begin
    w_wr_en_nxt      = r_wr_en;
    w_wr_addr_nxt    = r_wr_addr;
    w_wr_data_nxt    = r_wr_data;
    w_ptr_nxt        = r_ptr;
    w_count_nxt      = r_count;
    w_err_nxt        = 1'b0;
    w_err_sticky_nxt = r_err_sticky;

    if (w_drain) begin
      w_wr_en_nxt = 1'b0;
      w_count_nxt = r_count + CNT_W'(1);
    end

    if (w_accept && w_legal) begin
      w_wr_en_nxt   = 1'b1;
      w_wr_addr_nxt = w_base;
      w_wr_data_nxt = w_word;
      w_ptr_nxt     = w_base + AW'(4);
    end else if (addr_load) begin
      // Pointer load without a legal accept leaves any held word untouched
      w_ptr_nxt = w_load_aligned;
    end

    if (w_accept && !w_legal) begin
      w_err_nxt        = 1'b1;
      w_err_sticky_nxt = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_err        <= 1'b0;
      r_err_sticky <= 1'b0;
      r_count      <= '0;
      r_ptr        <= '0;
    end else begin
      r_wr_en      <= w_wr_en_nxt;
      r_wr_addr    <= w_wr_addr_nxt;
      r_wr_data    <= w_wr_data_nxt;
      r_err        <= w_err_nxt;
      r_err_sticky <= w_err_sticky_nxt;
      r_count      <= w_count_nxt;
      r_ptr        <= w_ptr_nxt;
    end
  end

  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign err        = r_err;
  assign err_sticky = r_err_sticky;
  assign count      = r_count;

endmodule
